// File: rtl/kn_sched_pkg.sv
// Shared constants and types for the Kn-scaling pipeline scheduler.
package kn_sched_pkg;

   localparam int unsigned W_DEF       = 12;
   localparam int unsigned NREQ_DEF    = 2;
   localparam int unsigned MUL_LAT_DEF = 4;
   localparam int unsigned CNT_W       = 16;

   // Requester index width, never narrower than one bit
   function automatic int unsigned tag_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned TAG_W = tag_width(NREQ_DEF);

   typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/kn_rr_arb.sv
// Round-robin arbiter: one-hot grant, search begins at the priority pointer.
module kn_rr_arb #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] pointer,
   input  logic             ce,
   output logic [NREQ-1:0]  grant
);

   localparam int unsigned IDX_W = PTR_W + 1;

   logic [IDX_W-1:0] idx;
   logic             found;

   // Scan requesters in rotated order, first requester found wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = IDX_W'(pointer) + IDX_W'(i);
         if (idx >= IDX_W'(NREQ)) begin
            idx = idx - IDX_W'(NREQ);
         end
         if (ce && !found && req[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/kn_mul_sched.sv
// Schedules NREQ requesters onto one shared Kn-scaling pipeline and routes
// results back by tag. Optional per-requester grant counters are built when
// KN_SCHED_STATS_EN is defined.
module kn_mul_sched
   import kn_sched_pkg::*;
#(
   parameter int unsigned W       = W_DEF,
   parameter int unsigned NREQ    = NREQ_DEF,
   parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              mul_ce,
   output logic [W-1:0]      mul_in,
   input  logic [W-1:0]      mul_out,
   output logic [NREQ-1:0]   res_valid,
   output logic [W-1:0]      res_data,
   input  logic              res_ready,
   output logic              idle
`ifdef KN_SCHED_STATS_EN
   ,
   output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

   localparam int unsigned TW = tag_width(NREQ);

   logic [MUL_LAT-1:0] vld_q;
   logic [MUL_LAT-1:0] vld_d;
   logic [TW-1:0]      tag_q [MUL_LAT];
   logic [TW-1:0]      tag_d [MUL_LAT];
   logic [TW-1:0]      ptr_q;
   logic [TW-1:0]      ptr_d;
   logic [NREQ-1:0]    grant;
   logic [TW-1:0]      gnt_idx;
   logic               stall;
   logic               arb_ce;

   // Result side: decode the last stage, derive stall and the pipeline enable
   always_comb begin
      res_valid = '0;
      if (vld_q[MUL_LAT-1]) begin
         res_valid[tag_q[MUL_LAT-1]] = 1'b1;
      end
      stall    = (|res_valid) & ~res_ready;
      mul_ce   = ~stall;
      res_data = mul_out;
      idle     = ~(|vld_q);
   end

   // No grants while stalled or held in reset
   assign arb_ce = mul_ce & ~reset;

   kn_rr_arb #(
      .NREQ  (NREQ),
      .PTR_W (TW)
   ) u_arb (
      .req     (req_valid),
      .pointer (ptr_q),
      .ce      (arb_ce),
      .grant   (grant)
   );

   // Grant side: steer the granted sample into the pipeline and encode its index
   always_comb begin
      req_ready = grant;
      mul_in    = '0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            mul_in  = req_data[i*W +: W];
            gnt_idx = TW'(i);
         end
      end
   end

   // Next state: tag pipe advances with the pipeline, pointer moves past the winner
   always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      ptr_d = ptr_q;
      if (mul_ce) begin
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
         end
         vld_d[0] = |grant;
         tag_d[0] = gnt_idx;
      end
      if (|grant) begin
         ptr_d = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
      end
   end

   // Tag pipe and pointer registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         ptr_q <= '0;
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         ptr_q <= ptr_d;
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

`ifdef KN_SCHED_STATS_EN
   logic [CNT_W-1:0] cnt_q [NREQ];
   logic [CNT_W-1:0] cnt_d [NREQ];

   // Saturating per-requester grant counters
   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Flatten counters onto the output bus
   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_kn_mul_sched.sv
// Bench for kn_mul_sched: scoreboard in grant order plus scenario tasks.
module tb_kn_mul_sched;

   localparam int W       = 12;
   localparam int NREQ    = 2;
   localparam int MUL_LAT = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*W-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic              mul_ce;
   logic [W-1:0]      mul_in;
   logic [W-1:0]      mul_out;
   logic [NREQ-1:0]   res_valid;
   logic [W-1:0]      res_data;
   logic              res_ready = 1'b1;
   logic              idle;
`ifdef KN_SCHED_STATS_EN
   logic [NREQ*16-1:0] grant_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   kn_mul_sched #(.W(W), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .mul_ce    (mul_ce),
      .mul_in    (mul_in),
      .mul_out   (mul_out),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .idle      (idle)
`ifdef KN_SCHED_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   // Kn scaling used by the external pipeline: x * 0.625, arithmetic shift
   function automatic logic [W-1:0] kn_scale(input logic [W-1:0] x);
      int v;
      v = int'($signed(x)) * 5;
      v = v >>> 3;
      return v[W-1:0];
   endfunction

   // External shared pipeline: MUL_LAT stages, advanced only when mul_ce is high
   logic [W-1:0] pipe [MUL_LAT];
   always @(posedge clock) begin
      if (mul_ce) begin
         for (int i = MUL_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= kn_scale(mul_in);
      end
   end
   assign mul_out = pipe[MUL_LAT-1];

   // Reference model: in-order queue of accepted samples, each stamped with the
   // count of enabled edges at acceptance; it is visible once MUL_LAT-1 more
   // enabled edges have passed.
   typedef struct {
      int          req;
      logic [W-1:0] val;
      int          a;
   } item_t;

   item_t           q[$];
   int              ptr_m  = 0;
   int              ce_cnt = 0;
   int              e_gnt  = -1;
   int              cand;
   logic            e_ce   = 1'b1;
   logic            head_vis = 1'b0;
   logic [NREQ-1:0] exp_rv;
   logic [NREQ-1:0] exp_rr;
   logic [W-1:0]    exp_in;
   logic            exp_idle;
   item_t           it;

   // Per-cycle prediction and comparison of every output
   always @(negedge clock) begin
      exp_rv = '0;
      exp_rr = '0;
      exp_in = '0;
      e_gnt  = -1;
      if (reset) begin
         e_ce     = 1'b1;
         head_vis = 1'b0;
         exp_idle = 1'b1;
      end else begin
         head_vis = (q.size() > 0) && (ce_cnt - q[0].a == MUL_LAT - 1);
         if (head_vis) exp_rv[q[0].req] = 1'b1;
         e_ce = !(head_vis && !res_ready);
         if (e_ce) begin
            for (int k = 0; k < NREQ; k++) begin
               cand = (ptr_m + k) % NREQ;
               if (e_gnt < 0 && req_valid[cand]) e_gnt = cand;
            end
         end
         if (e_gnt >= 0) begin
            exp_rr[e_gnt] = 1'b1;
            exp_in = req_data[e_gnt*W +: W];
         end
         exp_idle = (q.size() == 0);
      end
      n_total++;
      if (res_valid !== exp_rv) $display("FAIL sb_res_valid t=%0t got=%b exp=%b", $time, res_valid, exp_rv);
      else n_pass++;
      n_total++;
      if (req_ready !== exp_rr) $display("FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rr);
      else n_pass++;
      n_total++;
      if (mul_ce !== e_ce) $display("FAIL sb_mul_ce t=%0t got=%b exp=%b", $time, mul_ce, e_ce);
      else n_pass++;
      n_total++;
      if (mul_in !== exp_in) $display("FAIL sb_mul_in t=%0t got=%h exp=%h", $time, mul_in, exp_in);
      else n_pass++;
      n_total++;
      if (idle !== exp_idle) $display("FAIL sb_idle t=%0t got=%b exp=%b", $time, idle, exp_idle);
      else n_pass++;
      if (head_vis) begin
         n_total++;
         if (res_data !== q[0].val) $display("FAIL sb_res_data t=%0t got=%h exp=%h", $time, res_data, q[0].val);
         else n_pass++;
      end
   end

   // Model state update at each active edge
   always @(posedge clock) begin
      if (reset) begin
         q.delete();
         ptr_m = 0;
      end else if (e_ce) begin
         ce_cnt++;
         if (head_vis && res_ready) void'(q.pop_front());
         if (e_gnt >= 0) begin
            it.req = e_gnt;
            it.val = kn_scale(req_data[e_gnt*W +: W]);
            it.a   = ce_cnt;
            q.push_back(it);
            ptr_m = (e_gnt + 1) % NREQ;
         end
      end
   end

   task automatic reset_pulse();
      @(posedge clock); #1;
      reset = 1'b1;
      req_valid = '0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      req_data  = {12'h123, 12'h456};
      @(negedge clock);
      n_total++;
      if (res_valid !== 2'b00) $display("FAIL rst_res_valid got=%b exp=00", res_valid); else n_pass++;
      n_total++;
      if (req_ready !== 2'b00) $display("FAIL rst_req_ready got=%b exp=00", req_ready); else n_pass++;
      n_total++;
      if (mul_ce !== 1'b1) $display("FAIL rst_mul_ce got=%b exp=1", mul_ce); else n_pass++;
      n_total++;
      if (mul_in !== 12'h000) $display("FAIL rst_mul_in got=%h exp=000", mul_in); else n_pass++;
      n_total++;
      if (idle !== 1'b1) $display("FAIL rst_idle got=%b exp=1", idle); else n_pass++;
`ifdef KN_SCHED_STATS_EN
      n_total++;
      if (grant_cnt !== 32'h0) $display("FAIL rst_grant_cnt got=%h exp=0", grant_cnt); else n_pass++;
`endif
      @(posedge clock); #1;
      reset = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_single();
      int cyc;
      bit seen;
      @(posedge clock); #1;
      req_valid = 2'b01;
      req_data  = {12'h000, 12'h100};
      res_ready = 1'b1;
      @(negedge clock);
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL single_grant got=%b exp=01", req_ready); else n_pass++;
      @(posedge clock); #1;
      req_valid = '0;
      cyc  = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         cyc++;
         if (res_valid !== 2'b00) seen = 1;
      end
      n_total++;
      if (!seen || cyc != 4) $display("FAIL single_latency got=%0d exp=4 seen=%0d", cyc, seen); else n_pass++;
      n_total++;
      if (res_valid !== 2'b01) $display("FAIL single_res_valid got=%b exp=01", res_valid); else n_pass++;
      n_total++;
      if (res_data !== 12'h0A0) $display("FAIL single_res_data got=%h exp=0a0", res_data); else n_pass++;
      @(posedge clock); #1;
      @(negedge clock);
      n_total++;
      if (idle !== 1'b1) $display("FAIL single_idle got=%b exp=1", idle); else n_pass++;
   endtask

   task automatic test_contention();
      logic [NREQ-1:0] alt;
      logic [NREQ-1:0] want;
      reset_pulse();
      res_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(posedge clock); #1;
         req_valid = (c < 6) ? 2'b11 : 2'b00;
         req_data  = {W'($urandom), W'($urandom)};
         @(negedge clock);
         want = '0;
         if (c < 6) begin
            alt  = (c % 2 == 0) ? 2'b01 : 2'b10;
            want = alt;
         end
         n_total++;
         if (req_ready !== want) $display("FAIL cont_grant c=%0d got=%b exp=%b", c, req_ready, want); else n_pass++;
         want = '0;
         if (c >= 4 && c < 10) want = ((c - 4) % 2 == 0) ? 2'b01 : 2'b10;
         n_total++;
         if (res_valid !== want) $display("FAIL cont_result c=%0d got=%b exp=%b", c, res_valid, want); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      bit seen;
      logic [NREQ-1:0] hv;
      logic [W-1:0] hd;
      @(posedge clock); #1;
      res_ready = 1'b0;
      req_valid = 2'b01;
      req_data  = {12'h000, W'($urandom)};
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if (res_valid !== 2'b00) seen = 1;
         else begin
            @(posedge clock); #1;
            req_data = {12'h000, W'($urandom)};
         end
      end
      n_total++;
      if (!seen) $display("FAIL bp_wait got=timeout exp=res_valid"); else n_pass++;
      hv = res_valid;
      hd = res_data;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) @(negedge clock);
         n_total++;
         if (mul_ce !== 1'b0) $display("FAIL bp_mul_ce j=%0d got=%b exp=0", j, mul_ce); else n_pass++;
         n_total++;
         if (req_ready !== 2'b00) $display("FAIL bp_req_ready j=%0d got=%b exp=00", j, req_ready); else n_pass++;
         n_total++;
         if (res_data !== hd || res_valid !== hv) $display("FAIL bp_hold j=%0d got=%h/%b exp=%h/%b", j, res_data, res_valid, hd, hv);
         else n_pass++;
      end
      @(posedge clock); #1;
      res_ready = 1'b1;
      repeat (5) begin
         @(posedge clock); #1;
         req_data = {12'h000, W'($urandom)};
      end
      req_valid = '0;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clock);
         if (idle === 1'b1) seen = 1;
      end
      n_total++;
      if (!seen) $display("FAIL bp_drain got=idle_low exp=idle_high"); else n_pass++;
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         req_valid = 2'b11;
         req_data  = {W'($urandom), W'($urandom)};
      end
      @(posedge clock); #1;
      req_valid = '0;
      @(negedge clock);
      n_total++;
      if (idle !== 1'b0) $display("FAIL mid_inflight got=%b exp=0", idle); else n_pass++;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      n_total++;
      if (idle !== 1'b1) $display("FAIL mid_rst_idle got=%b exp=1", idle); else n_pass++;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         n_total++;
         if (res_valid !== 2'b00 || idle !== 1'b1)
            $display("FAIL mid_after c=%0d got=%b/%b exp=00/1", c, res_valid, idle);
         else n_pass++;
      end
      @(posedge clock); #1;
      req_valid = 2'b11;
      @(negedge clock);
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL mid_ptr got=%b exp=01", req_ready); else n_pass++;
      @(posedge clock); #1;
      req_valid = '0;
      repeat (MUL_LAT + 2) @(posedge clock);
   endtask

   task automatic test_random();
      bit seen;
      for (int c = 0; c < 400; c++) begin
         @(posedge clock); #1;
         req_valid = NREQ'($urandom);
         req_data  = {W'($urandom), W'($urandom)};
         res_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clock); #1;
      req_valid = '0;
      res_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clock);
         if (idle === 1'b1) seen = 1;
      end
      n_total++;
      if (!seen || q.size() != 0) $display("FAIL rand_drain got=%0d left exp=0", q.size()); else n_pass++;
   endtask

`ifdef KN_SCHED_STATS_EN
   task automatic test_stats();
      reset_pulse();
      res_ready = 1'b1;
      req_valid = 2'b10;
      repeat (100) @(posedge clock);
      @(negedge clock);
      n_total++;
      if (grant_cnt[31:16] !== 16'd100) $display("FAIL stats_mid got=%0d exp=100", grant_cnt[31:16]); else n_pass++;
      repeat (69900) @(posedge clock);
      #1;
      req_valid = '0;
      @(negedge clock);
      n_total++;
      if (grant_cnt[31:16] !== 16'hFFFF) $display("FAIL stats_sat got=%h exp=ffff", grant_cnt[31:16]); else n_pass++;
      n_total++;
      if (grant_cnt[15:0] !== 16'h0) $display("FAIL stats_zero got=%h exp=0000", grant_cnt[15:0]); else n_pass++;
   endtask
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef KN_SCHED_STATS_EN
      test_stats();
`endif
      @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
